alu_rs_bank: RTL

//  Multi-entry ALU reservation station for the Tomasulo LC-3b core. Sits between issue control and the

---
 rtl/alu_rs_bank.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_rs_bank.sv
// ALU reservation station bank: buffers issued ALU ops, snoops the CDB for
// missing operands, dispatches the oldest ready op through the ALU and holds
// the result until the CDB arbiter grants it.
module alu_rs_bank #(
    parameter int ENTRIES = 4,
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic [3:0]        issue_op,
    input  logic [DATA_W-1:0] issue_Vj,
    input  logic [DATA_W-1:0] issue_Vk,
    input  logic              issue_Rj,
    input  logic              issue_Rk,
    input  logic [TAG_W-1:0]  issue_Qj,
    input  logic [TAG_W-1:0]  issue_Qk,
    input  logic [TAG_W-1:0]  issue_dest,
    output logic              full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              out_valid,
    output logic [TAG_W-1:0]  out_tag,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_grant
);
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_SHF = 4'b1101;

    logic [ENTRIES-1:0]             busy_q, busy_d, rj_q, rj_d, rk_q, rk_d;
    logic [ENTRIES-1:0][3:0]        op_q, op_d;
    logic [ENTRIES-1:0][DATA_W-1:0] vj_q, vj_d, vk_q, vk_d;
    logic [ENTRIES-1:0][TAG_W-1:0]  qj_q, qj_d, qk_q, qk_d, dest_q, dest_d;
    // age_q[i][j] = 1 means entry i was allocated before entry j
    logic [ENTRIES-1:0][ENTRIES-1:0] age_q, age_d;
    logic                           out_valid_q, out_valid_d;
    logic [TAG_W-1:0]               out_tag_q, out_tag_d;
    logic [DATA_W-1:0]              out_data_q, out_data_d;

    logic [ENTRIES-1:0] ready, sel_oh, disp_oh, free, alloc_oh;
    logic               disp_en, do_issue, alloc_found;
    logic [3:0]         sel_op;
    logic [DATA_W-1:0]  sel_vj, sel_vk, alu_res;
    logic [TAG_W-1:0]   sel_dest;
    logic [3:0]         shamt;

    assign full      = &busy_q;
    assign out_valid = out_valid_q;
    assign out_tag   = out_tag_q;
    assign out_data  = out_data_q;

    // Oldest-ready select, operand mux, ALU and lowest-free allocation
    always_comb begin
        ready    = busy_q & rj_q & rk_q;
        sel_oh   = '0;
        sel_op   = '0;
        sel_vj   = '0;
        sel_vk   = '0;
        sel_dest = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            sel_oh[i] = ready[i];
            for (int j = 0; j < ENTRIES; j++)
                if (j != i && ready[j] && age_q[j][i]) sel_oh[i] = 1'b0;
            sel_op   = sel_op   | ({4{sel_oh[i]}} & op_q[i]);
            sel_vj   = sel_vj   | ({DATA_W{sel_oh[i]}} & vj_q[i]);
            sel_vk   = sel_vk   | ({DATA_W{sel_oh[i]}} & vk_q[i]);
            sel_dest = sel_dest | ({TAG_W{sel_oh[i]}} & dest_q[i]);
        end
        disp_en = (!out_valid_q || out_grant) && (|ready);
        disp_oh = disp_en ? sel_oh : '0;

        shamt = sel_vk[3:0];
        case (sel_op)
            OP_AND:  alu_res = sel_vj & sel_vk;
            OP_NOT:  alu_res = ~sel_vj;
            OP_SHF: begin
                if (!sel_vk[4])      alu_res = sel_vj << shamt;
                else if (!sel_vk[5]) alu_res = sel_vj >> shamt;
                else                 alu_res = DATA_W'($signed(sel_vj) >>> shamt);
            end
            default: alu_res = sel_vj + sel_vk;
        endcase

        // a slot freed by this edge's dispatch is reusable at the same edge
        free        = ~busy_q | disp_oh;
        alloc_oh    = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < ENTRIES; i++)
            if (free[i] && !alloc_found) begin
                alloc_oh[i] = 1'b1;
                alloc_found = 1'b1;
            end
        do_issue = issue_valid && !full;
    end

    // Next state: dispatch free, CDB wakeup, issue write with bypass, output reg
    always_comb begin
        busy_d = busy_q & ~disp_oh;
        rj_d = rj_q; rk_d = rk_q; op_d = op_q;
        vj_d = vj_q; vk_d = vk_q; qj_d = qj_q; qk_d = qk_q;
        dest_d = dest_q; age_d = age_q;
        out_valid_d = out_valid_q;
        out_tag_d   = out_tag_q;
        out_data_d  = out_data_q;

        for (int i = 0; i < ENTRIES; i++) begin
            if (busy_q[i] && !rj_q[i] && cdb_valid && qj_q[i] == cdb_tag) begin
                vj_d[i] = cdb_data;
                rj_d[i] = 1'b1;
            end
            if (busy_q[i] && !rk_q[i] && cdb_valid && qk_q[i] == cdb_tag) begin
                vk_d[i] = cdb_data;
                rk_d[i] = 1'b1;
            end
            if (do_issue && alloc_oh[i]) begin
                busy_d[i] = 1'b1;
                op_d[i]   = issue_op;
                qj_d[i]   = issue_Qj;
                qk_d[i]   = issue_Qk;
                dest_d[i] = issue_dest;
                rj_d[i]   = issue_Rj || (cdb_valid && issue_Qj == cdb_tag);
                rk_d[i]   = issue_Rk || (cdb_valid && issue_Qk == cdb_tag);
                vj_d[i]   = issue_Rj ? issue_Vj : cdb_data;
                vk_d[i]   = issue_Rk ? issue_Vk : cdb_data;
                // new entry is younger than everyone else
                age_d[i]  = '0;
                for (int j = 0; j < ENTRIES; j++)
                    if (j != i) age_d[j][i] = 1'b1;
            end
        end

        if (disp_en) begin
            out_valid_d = 1'b1;
            out_tag_d   = sel_dest;
            out_data_d  = alu_res;
        end else if (out_grant) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            busy_d      = '0;
            out_valid_d = 1'b0;
            out_tag_d   = '0;
            out_data_d  = '0;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0; rj_q <= '0; rk_q <= '0; op_q <= '0;
            vj_q <= '0; vk_q <= '0; qj_q <= '0; qk_q <= '0;
            dest_q <= '0; age_q <= '0;
            out_valid_q <= 1'b0; out_tag_q <= '0; out_data_q <= '0;
        end else begin
            busy_q <= busy_d; rj_q <= rj_d; rk_q <= rk_d; op_q <= op_d;
            vj_q <= vj_d; vk_q <= vk_d; qj_q <= qj_d; qk_q <= qk_d;
            dest_q <= dest_d; age_q <= age_d;
            out_valid_q <= out_valid_d; out_tag_q <= out_tag_d; out_data_q <= out_data_d;
        end
    end
endmodule
